seg_scan_ctrl: RTL and testbench

- Scan scheduler for the 4-digit seven-segment display shared by the detector results: time-multiplexes one segment bus across four digit enables.
- Adds a programmable blanking gap between digits to remove ghosting.
- Double-buffers display data so updates take effect only at frame boundaries, with no tearing.
- Sits between result/status logic (e.g. the sequence-detector count) and the dig/smg pins; replaces ad-hoc sel counters and per-digit mux blocks.

---
 rtl/seg_scan_ctrl_pkg.sv | 42 ++++
 rtl/seg_scan_ctrl_hex_to_seg.sv | 19 +
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_pkg
// Brief   : Shared types, constants and hex-to-segment table for the scanner.
// Revision: 1.0
// ============================================================================
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Active-low g..a patterns for hex digits 0..F.
    function automatic logic [6:0] seg7_lut(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module  : hex_to_seg
// Brief   : Combinational 4-bit hex to active-low 7-segment (g..a) decoder.
// Revision: 1.0
// ============================================================================
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg7_lut(hex);
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_ctrl
// Brief   : 4-digit seven-segment scan scheduler with inter-digit blanking and
//           frame-synchronous double-buffered display data.
// Revision: 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] digit_data,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    output logic        load_ack,
    output logic        frame_done,
    output logic [3:0]  dig,
    output logic [7:0]  smg
);

    localparam int               CNT_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        stg_data_q, stg_data_d, act_data_q, act_data_d;
    logic [3:0]         stg_dp_q, stg_dp_d, act_dp_q, act_dp_d;
    logic [3:0]         stg_blank_q, stg_blank_d, act_blank_q, act_blank_d;
    logic               pending_q, pending_d;
    logic               load_ack_q, load_ack_d;
    logic               frame_done_q, frame_done_d;
    logic [3:0]         dig_q, dig_d;
    logic [7:0]         smg_q, smg_d;
    logic               slot_end;
    logic               frame_bnd;
    logic [3:0]         cur_nibble;
    logic [6:0]         cur_seg;

    assign cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    // Slot sequencing; en low overrides everything and parks the scanner.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        slot_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_SHOW;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHOW_LAST) begin
                    if (BLANK_CYC == 0) begin
                        slot_end = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end
            end
            ST_BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SLOT_LAST) begin
                    slot_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (slot_end) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            idx_d   = idx_q + 1'b1;
        end
        if (!en) begin
            state_d  = ST_IDLE;
            idx_d    = 2'd0;
            cnt_d    = '0;
            slot_end = 1'b0;
        end
    end

    assign frame_bnd = slot_end && (idx_q == 2'd3);

    // Staging/active double buffer; a load coinciding with the boundary bypasses staging.
    always_comb begin
        stg_data_d   = stg_data_q;
        stg_dp_d     = stg_dp_q;
        stg_blank_d  = stg_blank_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pending_d    = pending_q;
        load_ack_d   = 1'b0;
        frame_done_d = 1'b0;
        if (load) begin
            stg_data_d  = digit_data;
            stg_dp_d    = dp_mask;
            stg_blank_d = blank_mask;
        end
        if (frame_bnd) begin
            frame_done_d = 1'b1;
            if (load) begin
                act_data_d  = digit_data;
                act_dp_d    = dp_mask;
                act_blank_d = blank_mask;
                pending_d   = 1'b0;
                load_ack_d  = 1'b1;
            end else if (pending_q) begin
                act_data_d  = stg_data_q;
                act_dp_d    = stg_dp_q;
                act_blank_d = stg_blank_q;
                pending_d   = 1'b0;
                load_ack_d  = 1'b1;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    always_comb begin
        dig_d = 4'hF;
        smg_d = SEG_OFF;
        if (en && (state_q == ST_SHOW) && !act_blank_q[idx_q]) begin
            dig_d = ~(4'b0001 << idx_q);
            smg_d = {~act_dp_q[idx_q], cur_seg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            stg_data_q   <= '0;
            stg_dp_q     <= '0;
            stg_blank_q  <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pending_q    <= 1'b0;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dig_q        <= 4'hF;
            smg_q        <= SEG_OFF;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            stg_data_q   <= stg_data_d;
            stg_dp_q     <= stg_dp_d;
            stg_blank_q  <= stg_blank_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pending_q    <= pending_d;
            load_ack_q   <= load_ack_d;
            frame_done_q <= frame_done_d;
            dig_q        <= dig_d;
            smg_q        <= smg_d;
        end
    end

    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;
    assign dig        = dig_q;
    assign smg        = smg_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_ctrl
// Brief   : Scoreboard bench for seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// Revision: 1.0
// ============================================================================
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blank_mask = '0;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  dig;
    logic [7:0]  smg;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        int         cyc;
        logic [3:0] dig;
        logic [7:0] smg;
    } lit_t;

    typedef struct packed {
        int   cyc;
        logic ack;
    } ev_t;

    lit_t lit_q[$];
    ev_t  ev_q[$];

    seg_scan_ctrl #(
        .SCAN_DIV  (8),
        .BLANK_CYC (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .digit_data (digit_data),
        .dp_mask    (dp_mask),
        .blank_mask (blank_mask),
        .load_ack   (load_ack),
        .frame_done (frame_done),
        .dig        (dig),
        .smg        (smg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] seg_ref(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
            4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
            4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
            4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s @cyc %0d: actual=%h required=%h", name, cyc, act, req);
    endtask

    // Expected lit samples for scan times a..b of a scan that started at t;
    // output for scan time tau appears at cycle t+tau+2.
    task automatic push_lit(input int t, input int a, input int b,
                            input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        for (int tau = a; tau <= b; tau++) begin
            int         s;
            int         c;
            logic [3:0] dg;
            logic [3:0] nib;
            lit_t       e;
            s   = (tau / 8) % 4;
            c   = tau % 8;
            dg  = 4'b0001 << s;
            nib = d[s*4 +: 4];
            if (c < 6 && !bl[s]) begin
                e.cyc = t + tau + 2;
                e.dig = ~dg;
                e.smg = {~dp[s], seg_ref(nib)};
                lit_q.push_back(e);
            end
        end
    endtask

    task automatic push_ev(input int c, input logic ack);
        ev_t e;
        e.cyc = c;
        e.ack = ack;
        ev_q.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int at, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        wait_until(at);
        load       = 1'b1;
        digit_data = d;
        dp_mask    = dp;
        blank_mask = bl;
        wait_until(at + 1);
        load       = 1'b0;
    endtask

    // Monitor: every non-dark sample and every pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dig !== 4'hF || smg !== 8'hFF) begin
                if (lit_q.size() == 0) begin
                    chk("lit_unexpected", 1'b0, {cyc, dig, smg}, 64'h0);
                end else begin
                    lit_t e;
                    e = lit_q.pop_front();
                    chk("lit_sample", (e.cyc == cyc) && (e.dig === dig) && (e.smg === smg),
                        {cyc, dig, smg}, {e.cyc, e.dig, e.smg});
                end
            end
            if (frame_done !== 1'b0 || load_ack !== 1'b0) begin
                if (ev_q.size() == 0) begin
                    chk("pulse_unexpected", 1'b0, {cyc, frame_done, load_ack}, 64'h0);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("frame_pulse", (e.cyc == cyc) && (frame_done === 1'b1) && (load_ack === e.ack),
                        {cyc, frame_done, load_ack}, {e.cyc, 1'b1, e.ack});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int t1;
        int t2;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dig", dig === 4'hF, 64'(dig), 64'hF);
        chk("reset_smg", smg === 8'hFF, 64'(smg), 64'hFF);
        chk("reset_pulses", {frame_done, load_ack} === 2'b00, 64'({frame_done, load_ack}), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Scan start with blank buffers, then a load exactly at the first boundary.
        en = 1'b1;
        t0 = cyc;
        push_lit(t0, 0, 31, 16'h0000, 4'h0, 4'h0);
        push_ev(t0 + 33, 1'b1);
        push_lit(t0, 32, 63, 16'h3210, 4'h0, 4'h0);
        push_ev(t0 + 65, 1'b0);
        push_lit(t0, 64, 95, 16'h3210, 4'h0, 4'h0);
        do_load(t0 + 32, 16'h3210, 4'h0, 4'h0);

        // Mid-frame load: takes effect only after the next frame boundary.
        do_load(t0 + 74, 16'hFEDC, 4'b0001, 4'h0);
        push_ev(t0 + 97, 1'b1);
        push_lit(t0, 96, 127, 16'hFEDC, 4'b0001, 4'h0);

        // Two loads in one frame: last wins, one acknowledge.
        do_load(t0 + 101, 16'h1111, 4'h0, 4'h0);
        do_load(t0 + 116, 16'h2222, 4'h0, 4'h0);
        push_ev(t0 + 129, 1'b1);
        push_lit(t0, 128, 159, 16'h2222, 4'h0, 4'h0);

        // Digit 2 blanked for whole slots.
        do_load(t0 + 136, 16'h3210, 4'h0, 4'b0100);
        push_ev(t0 + 161, 1'b1);
        push_lit(t0, 160, 191, 16'h3210, 4'h0, 4'b0100);
        push_ev(t0 + 193, 1'b0);
        push_lit(t0, 192, 201, 16'h3210, 4'h0, 4'b0100);

        // en drops during digit 1 (cnt=2); dark next cycle and no frame pulse.
        wait_until(t0 + 203);
        en = 1'b0;
        wait_until(t0 + 215);

        // Restart from digit 0 with retained data; stage a load, then reset during digit-3 blank.
        en = 1'b1;
        t1 = cyc;
        push_lit(t1, 0, 31, 16'h3210, 4'h0, 4'b0100);
        do_load(t1 + 10, 16'h9999, 4'hF, 4'h0);
        wait_until(t1 + 32);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_dig", dig === 4'hF, 64'(dig), 64'hF);
        chk("midreset_smg", smg === 8'hFF, 64'(smg), 64'hFF);
        chk("midreset_pulses", {frame_done, load_ack} === 2'b00, 64'({frame_done, load_ack}), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midreset_hold_dig", dig === 4'hF, 64'(dig), 64'hF);
        rst_n = 1'b1;
        t2 = cyc;

        // After release the active buffer is zero and the staged load is gone.
        push_lit(t2, 0, 31, 16'h0000, 4'h0, 4'h0);
        push_ev(t2 + 33, 1'b0);
        wait_until(t2 + 33);
        en = 1'b0;
        wait_until(t2 + 45);

        chk("lit_queue_drained", lit_q.size() == 0, 64'(lit_q.size()), 64'h0);
        chk("pulse_queue_drained", ev_q.size() == 0, 64'(ev_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
